// File: rtl/bitstream_byte_drain.sv
// Byte drain for the Stage 4 carry-propagation output: buffers up to five bytes
// per cycle in a circular FWFT FIFO and emits them one per cycle over valid/ready.
module bitstream_byte_drain #(
  parameter int BITSTREAM_WIDTH = 8,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_flag_first,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_1,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_2,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_3,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_4,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_5,
  input  logic [2:0]                 in_flag,
  input  logic                       in_flag_last,
  output logic [BITSTREAM_WIDTH-1:0] out_byte,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       out_done,
  output logic                       out_overflow,
  output logic                       out_proto_err,
  output logic [FIFO_ADDR_WIDTH:0]   out_level
);

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int LW    = FIFO_ADDR_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH, S_DONE} state_t;

  state_t state, state_nxt;

  logic [BITSTREAM_WIDTH-1:0] mem [DEPTH];
  logic                       tag [DEPTH];
  logic [BITSTREAM_WIDTH-1:0] lane [5];

  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]              level, free;
  logic [2:0]                 cnt;
  logic                       illegal, restart, fits, do_write, drop, pop, proto_hit;

  // Lane counts 6 and 7 are not representable groups; they carry no data.
  function automatic logic [2:0] lane_count(input logic [2:0] flag);
    return (flag > 3'd5) ? 3'd0 : flag;
  endfunction

  assign lane[0] = in_bit_1;
  assign lane[1] = in_bit_2;
  assign lane[2] = in_bit_3;
  assign lane[3] = in_bit_4;
  assign lane[4] = in_bit_5;

  always_comb begin
    cnt       = lane_count(in_flag);
    illegal   = (in_flag > 3'd5);
    free      = DEPTH_L - level;
    fits      = (LW'(cnt) <= free);
    restart   = in_flag_first && ((state == S_ACTIVE) || (state == S_FLUSH));
    do_write  = (state == S_ACTIVE) && !in_flag_first && (cnt != 3'd0) && fits;
    drop      = (state == S_ACTIVE) && !in_flag_first && (cnt != 3'd0) && !fits;
    pop       = out_valid && out_ready;
    proto_hit = illegal;
    if (!in_flag_first) begin
      if (((state == S_IDLE) || (state == S_DONE)) && ((in_flag != 3'd0) || in_flag_last))
        proto_hit = 1'b1;
      if ((state == S_FLUSH) && (in_flag != 3'd0))
        proto_hit = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (in_flag_first) state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (in_flag_first)     state_nxt = S_ACTIVE;
        else if (in_flag_last) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (in_flag_first)        state_nxt = S_ACTIVE;
        else if (level == '0)     state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      out_overflow  <= 1'b0;
      out_proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (restart) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (do_write) wr_ptr <= wr_ptr + FIFO_ADDR_WIDTH'(cnt);
        if (pop)      rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(1);
        level <= level + (do_write ? LW'(cnt) : LW'(0)) - LW'(pop);
      end
      if (drop)      out_overflow  <= 1'b1;
      if (proto_hit) out_proto_err <= 1'b1;
    end
  end

  // Storage is never reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 5; i++) begin
        if (i < int'(cnt)) begin
          mem[wr_ptr + FIFO_ADDR_WIDTH'(i)] <= lane[i];
          tag[wr_ptr + FIFO_ADDR_WIDTH'(i)] <= in_flag_last && (i == int'(cnt) - 1);
        end
      end
    end
  end

  assign out_valid = (level != '0);
  assign out_byte  = out_valid ? mem[rd_ptr] : '0;
  assign out_last  = out_valid & tag[rd_ptr];
  assign out_done  = (state == S_DONE);
  assign out_level = level;

endmodule

// File: tb/tb_bitstream_byte_drain.sv
// Bench for bitstream_byte_drain: fixed vector table, directed multi-cycle
// sequences and randomized traffic against a queue-based reference model.
module tb_bitstream_byte_drain;

  localparam int W     = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  localparam int M_IDLE   = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_FLUSH  = 2;
  localparam int M_DONE   = 3;

  logic         clk;
  logic         reset;
  logic         in_flag_first;
  logic [W-1:0] in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5;
  logic [2:0]   in_flag;
  logic         in_flag_last;
  logic [W-1:0] out_byte;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         out_done;
  logic         out_overflow;
  logic         out_proto_err;
  logic [AW:0]  out_level;

  bitstream_byte_drain #(.BITSTREAM_WIDTH(W), .FIFO_ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_flag_first (in_flag_first),
    .in_bit_1      (in_bit_1),
    .in_bit_2      (in_bit_2),
    .in_bit_3      (in_bit_3),
    .in_bit_4      (in_bit_4),
    .in_bit_5      (in_bit_5),
    .in_flag       (in_flag),
    .in_flag_last  (in_flag_last),
    .out_byte      (out_byte),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .out_done      (out_done),
    .out_overflow  (out_overflow),
    .out_proto_err (out_proto_err),
    .out_level     (out_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: stream of {last_tag, byte} entries plus stream phase.
  bit [8:0] q[$];
  int       phase = M_IDLE;
  bit       m_ovf = 1'b0;
  bit       m_perr = 1'b0;

  typedef struct {
    bit        rst;
    bit        first;
    bit [2:0]  flag;
    bit        last;
    bit        ready;
    bit [39:0] lanes;
    bit [17:0] exp;
  } vec_t;

  function automatic bit [17:0] mk(bit v, bit [7:0] b, bit l, bit d, bit o, bit p, bit [4:0] lvl);
    return {v, b, l, d, o, p, lvl};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {out_valid, out_byte, out_last, out_done, out_overflow, out_proto_err, out_level};
  endfunction

  function automatic logic [17:0] model_vec();
    bit       v;
    bit [8:0] h;
    v = (q.size() != 0);
    h = v ? q[0] : 9'd0;
    return {v, h[7:0], h[8], (phase == M_DONE), m_ovf, m_perr, 5'(q.size())};
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int         n;
    int         free;
    bit         empty0;
    logic [7:0] ln [5];
    if (reset) begin
      q.delete();
      phase  = M_IDLE;
      m_ovf  = 1'b0;
      m_perr = 1'b0;
      return;
    end
    ln[0] = in_bit_1; ln[1] = in_bit_2; ln[2] = in_bit_3; ln[3] = in_bit_4; ln[4] = in_bit_5;
    empty0 = (q.size() == 0);
    free   = DEPTH - q.size();
    n      = (in_flag > 3'd5) ? 0 : int'(in_flag);
    if (in_flag > 3'd5) m_perr = 1'b1;
    if (!empty0 && out_ready) void'(q.pop_front());
    if (in_flag_first) begin
      if (phase == M_ACTIVE || phase == M_FLUSH) q.delete();
      phase = M_ACTIVE;
    end else begin
      case (phase)
        M_IDLE, M_DONE: if (in_flag != 3'd0 || in_flag_last) m_perr = 1'b1;
        M_ACTIVE: begin
          if (n > 0) begin
            if (n <= free) begin
              for (int i = 0; i < n; i++) q.push_back({(in_flag_last && i == n - 1), ln[i]});
            end else begin
              m_ovf = 1'b1;
            end
          end
          if (in_flag_last) phase = M_FLUSH;
        end
        M_FLUSH: begin
          if (in_flag != 3'd0) m_perr = 1'b1;
          if (empty0) phase = M_DONE;
        end
        default: phase = M_IDLE;
      endcase
    end
  endtask

  task automatic drive(input bit rst, input bit first, input bit [2:0] flag, input bit last,
                       input bit ready, input bit [39:0] lanes);
    reset         = rst;
    in_flag_first = first;
    in_flag       = flag;
    in_flag_last  = last;
    out_ready     = ready;
    in_bit_1      = lanes[7:0];
    in_bit_2      = lanes[15:8];
    in_bit_3      = lanes[23:16];
    in_bit_4      = lanes[31:24];
    in_bit_5      = lanes[39:32];
  endtask

  task automatic cyc(input string name, input bit rst, input bit first, input bit [2:0] flag,
                     input bit last, input bit ready, input bit [39:0] lanes);
    drive(rst, first, flag, last, ready, lanes);
    @(posedge clk);
    model_step();
    #1;
    check(name, dut_vec(), model_vec());
  endtask

  function automatic bit [39:0] rnd_lanes();
    return {8'($urandom), 32'($urandom)};
  endfunction

  vec_t tbl [15];

  initial begin
    drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 40'd0);

    tbl[0]  = '{1, 0, 3'd0, 0, 0, 40'h0,          mk(0, 8'h00, 0, 0, 0, 0, 5'd0)};
    tbl[1]  = '{0, 1, 3'd0, 0, 0, 40'h0,          mk(0, 8'h00, 0, 0, 0, 0, 5'd0)};
    tbl[2]  = '{0, 0, 3'd3, 0, 1, 40'h00_00A3A2A1, mk(1, 8'hA1, 0, 0, 0, 0, 5'd3)};
    tbl[3]  = '{0, 0, 3'd0, 0, 1, 40'h0,          mk(1, 8'hA2, 0, 0, 0, 0, 5'd2)};
    tbl[4]  = '{0, 0, 3'd0, 0, 1, 40'h0,          mk(1, 8'hA3, 0, 0, 0, 0, 5'd1)};
    tbl[5]  = '{0, 0, 3'd0, 0, 1, 40'h0,          mk(0, 8'h00, 0, 0, 0, 0, 5'd0)};
    tbl[6]  = '{0, 0, 3'd7, 0, 1, 40'h55_55555555, mk(0, 8'h00, 0, 0, 0, 1, 5'd0)};
    tbl[7]  = '{0, 0, 3'd2, 1, 0, 40'h00_0000B2B1, mk(1, 8'hB1, 0, 0, 0, 1, 5'd2)};
    tbl[8]  = '{0, 0, 3'd0, 0, 1, 40'h0,          mk(1, 8'hB2, 1, 0, 0, 1, 5'd1)};
    tbl[9]  = '{0, 0, 3'd0, 0, 1, 40'h0,          mk(0, 8'h00, 0, 0, 0, 1, 5'd0)};
    tbl[10] = '{0, 0, 3'd0, 0, 1, 40'h0,          mk(0, 8'h00, 0, 1, 0, 1, 5'd0)};
    tbl[11] = '{0, 1, 3'd0, 0, 1, 40'h0,          mk(0, 8'h00, 0, 0, 0, 1, 5'd0)};
    tbl[12] = '{0, 0, 3'd1, 0, 0, 40'h00_000000C1, mk(1, 8'hC1, 0, 0, 0, 1, 5'd1)};
    tbl[13] = '{1, 0, 3'd0, 0, 0, 40'h0,          mk(0, 8'h00, 0, 0, 0, 0, 5'd0)};
    tbl[14] = '{0, 0, 3'd2, 0, 0, 40'h00_0000D2D1, mk(0, 8'h00, 0, 0, 0, 1, 5'd0)};

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].first, tbl[i].flag, tbl[i].last, tbl[i].ready, tbl[i].lanes);
      @(posedge clk);
      model_step();
      #1;
      check($sformatf("vec%0d", i), dut_vec(), 18'(tbl[i].exp));
    end

    // Overrun: three 5-byte groups fit, the fourth is dropped whole.
    cyc("ovf_rst", 1, 0, 3'd0, 0, 0, 40'd0);
    cyc("ovf_first", 0, 1, 3'd0, 0, 0, 40'd0);
    for (int g = 0; g < 4; g++) cyc("ovf_fill", 0, 0, 3'd5, 0, 0, rnd_lanes());
    check("ovf_level", 18'(out_level), 18'd15);
    check("ovf_sticky", 18'(out_overflow), 18'd1);
    for (int i = 0; i < 15; i++) cyc("ovf_drain", 0, 0, 3'd0, 0, 1, 40'd0);
    check("ovf_empty", 18'({out_valid, out_level}), 18'd0);

    // Steady two-byte groups with toggling ready: wraps pointers, then overruns.
    cyc("wrap_rst", 1, 0, 3'd0, 0, 0, 40'd0);
    cyc("wrap_first", 0, 1, 3'd0, 0, 0, 40'd0);
    for (int i = 0; i < 40; i++) cyc("wrap", 0, 0, 3'd2, 0, (i % 2) == 0, rnd_lanes());
    for (int i = 0; i < 18; i++) cyc("wrap_drain", 0, 0, 3'd0, 0, 1, 40'd0);

    // Final group of four bytes: only the fourth carries the last tag.
    cyc("last4_rst", 1, 0, 3'd0, 0, 0, 40'd0);
    cyc("last4_first", 0, 1, 3'd0, 0, 0, 40'd0);
    cyc("last4_w0", 0, 0, 3'd3, 0, 0, rnd_lanes());
    cyc("last4_w1", 0, 0, 3'd4, 1, 0, 40'h00_44332211);
    for (int i = 0; i < 8; i++) cyc("last4_drain", 0, 0, 3'd0, 0, 1, 40'd0);
    check("last4_done", 18'(out_done), 18'd1);
    cyc("last4_restart", 0, 1, 3'd0, 0, 1, 40'd0);
    check("last4_done_clr", 18'(out_done), 18'd0);

    // Empty final group while two bytes remain buffered.
    cyc("last0_w", 0, 0, 3'd2, 0, 0, rnd_lanes());
    cyc("last0_mark", 0, 0, 3'd0, 1, 0, 40'd0);
    cyc("last0_hold", 0, 0, 3'd0, 0, 0, 40'd0);
    for (int i = 0; i < 4; i++) cyc("last0_drain", 0, 0, 3'd0, 0, 1, 40'd0);
    check("last0_done", 18'(out_done), 18'd1);

    // Reset mid-stream at level 9, then data before a stream start.
    cyc("mid_first", 0, 1, 3'd0, 0, 0, 40'd0);
    cyc("mid_w0", 0, 0, 3'd5, 0, 0, rnd_lanes());
    cyc("mid_w1", 0, 0, 3'd4, 0, 0, rnd_lanes());
    check("mid_level9", 18'(out_level), 18'd9);
    cyc("mid_rst", 1, 0, 3'd0, 0, 0, 40'd0);
    check("mid_rst_out", 18'({out_valid, out_level}), 18'd0);
    cyc("mid_idle_data", 0, 0, 3'd3, 0, 1, rnd_lanes());
    check("mid_idle_perr", 18'({out_proto_err, out_level}), 18'h20);

    // Randomized traffic.
    cyc("rnd_rst", 1, 0, 3'd0, 0, 0, 40'd0);
    for (int i = 0; i < 3000; i++) begin
      int f;
      f = int'($urandom_range(0, 39));
      cyc("rnd", ($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0),
          (f < 38) ? 3'(f % 6) : 3'(6 + f - 38), ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 2) != 0), rnd_lanes());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitstream_byte_drain.md
Name: bitstream_byte_drain

Overview:
- Receives the Stage 4 carry-propagation output: up to 5 bytes per cycle, with a 3-bit valid-count flag and a last flag.
- Buffers the bytes in a circular FIFO and emits them one byte per cycle over a valid/ready handshake. Emission order is byte 1 first.
- Stage 4 cannot be stalled. Overrun therefore drops data and is reported; it never back-pressures the encoder.
- Tracks end of stream and signals completion once the buffer drains.

Parameters:
- BITSTREAM_WIDTH, 8, width of each byte lane.
- FIFO_ADDR_WIDTH, 4, log2 of buffer depth. Depth = 2**FIFO_ADDR_WIDTH and must be at least 8.

Ports:
- clk, input, 1, single clock, rising edge.
- reset, input, 1, synchronous, active-high.
- in_flag_first, input, 1, start of a new stream; leaves DONE/IDLE.
- in_bit_1 .. in_bit_5, input, BITSTREAM_WIDTH each, byte lanes; lane 1 is oldest.
- in_flag, input, 3, number of valid lanes (0-5), filled from lane 1 upward.
- in_flag_last, input, 1, current group is the final group of the stream.
- out_byte, output, BITSTREAM_WIDTH, head byte.
- out_valid, output, 1, out_byte is valid.
- out_ready, input, 1, downstream accepts a byte.
- out_last, output, 1, head byte is the final byte of the stream.
- out_done, output, 1, stream fully drained.
- out_overflow, output, 1, sticky: a group was dropped.
- out_proto_err, output, 1, sticky: illegal in_flag, or data received outside ACTIVE.
- out_level, output, FIFO_ADDR_WIDTH+1, current occupancy.

Behaviour:
- Reset values: all outputs are 0, pointers are 0, and the state is IDLE. Buffer contents are not cleared but are unreachable.
- A reset in any state discards buffered bytes in the same edge.

State machine:
- IDLE:
  - in_flag_first moves to ACTIVE.
  - A nonzero in_flag or in_flag_last in IDLE sets out_proto_err; the data is ignored.
- ACTIVE:
  - Groups are accepted.
  - in_flag_last, in the same cycle as the group, moves to FLUSH. That group's data is still written.
- FLUSH:
  - Writes are ignored; a nonzero in_flag sets out_proto_err.
  - When level is 0 and no byte is in flight, moves to DONE.
- DONE:
  - out_done = 1 and is held.
  - in_flag_first moves to ACTIVE and clears out_done.
- in_flag_first while in ACTIVE or FLUSH restarts the stream: it flushes the pointers and moves to ACTIVE. Any group presented in that same cycle is dropped.

Write rules:
- in_flag 6 or 7 is treated as 0 and sets out_proto_err.
- Free space is computed as depth minus level before the same-cycle read.
- If in_flag exceeds free space, the whole group is dropped (never partially written) and out_overflow is set.
- Otherwise lanes 1..in_flag are written at wr_ptr..wr_ptr+in_flag-1 modulo depth, and wr_ptr advances by in_flag.

Per-entry last tag:
- In the last group, the highest valid lane's entry carries tag = 1; all other entries carry 0.
- A last group with in_flag = 0 tags nothing; only out_done reports the end of stream.

Read rules:
- The FIFO is first-word-fall-through.
- out_valid = (level != 0).
- out_byte and out_last are driven from the entry at rd_ptr.
- A byte written at edge N is visible at out_valid after edge N, i.e. 1-cycle latency.
- A pop occurs when out_valid && out_ready. rd_ptr then advances by 1 modulo depth.

Level and pointers:
- level_next = level + written - popped.
- A simultaneous write and pop are both honoured.
- Wrap-around is handled by pointer arithmetic modulo depth. Level reaches exactly depth (full) with no aliasing.

Sticky flags:
- out_overflow and out_proto_err clear only on reset. in_flag_first does not clear them.

Test Plan:
- Reset, in_flag_first, then one group with in_flag=3 and lanes 0xA1,0xA2,0xA3, out_ready=1. Expect out_byte = A1, A2, A3 on 3 consecutive cycles, starting 1 cycle after the write; out_valid falls after A3.
- out_ready=0, then four groups with in_flag=5 (20 bytes > depth 16). Expect the first 3 groups stored (level 15) and the 4th dropped, out_overflow=1. Then out_ready=1 drains exactly 15 bytes in order.
- Continuous in_flag=2 every cycle with out_ready toggling 1/0, run for 40 cycles. Pointers wrap; output sequence matches input order with no loss and no overflow until level would exceed 16.
- Last group in_flag=4 with in_flag_last=1. Expect out_last=1 only on the 4th byte of that group, then state DONE with out_done=1 the cycle after level reaches 0. A new in_flag_first clears out_done.
- Last group with in_flag=0 while level=2. Expect no out_last; out_done rises after the 2 bytes are popped. in_flag=7 in ACTIVE sets out_proto_err with no write.
- Reset asserted at level=9 mid-stream. Next cycle: out_valid=0, out_level=0, state IDLE. Data presented before in_flag_first sets out_proto_err and is not stored.
